fp_nan_prep: RTL
================

Name: fp_nan_prep

Overview:
- Operand pre-check stage for the single-precision FPU; produces the per-operand NaN flags and signs that the NaN sign-resolution/compare stage consumes.
- Classifies both operands and detects invalid operations for add/sub/mul/div.
- Generates the propagated or canonical quiet NaN.
- 2-stage pipeline with valid tracking, global stall and sticky exception flags.

Parameters:
- QNAN_CANON, 32'h7FC00000, canonical quiet NaN emitted on invalid operations with no NaN input.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  opa/opb/op qualify this cycle
- opa  input  32  IEEE-754 single operand A
- opb  input  32  IEEE-754 single operand B
- op  input  2  00 add, 01 sub, 10 mul, 11 div
- stall  input  1  freeze the whole pipeline
- flag_clr  input  1  clear the sticky flags
- out_valid  output  1  stage-2 outputs are valid
- opa_nan  output  1  A is NaN (quiet or signalling)
- opb_nan  output  1  B is NaN
- signa_o  output  1  sign of A, aligned with the flags
- signb_o  output  1  sign of B, aligned with the flags
- nan_res  output  1  result must be NaN (input NaN or invalid)
- nan_val  output  32  NaN result value; 0 when nan_res=0
- invalid  output  1  invalid-operation exception for this result
- snan_sticky  output  1  sticky: any SNaN input seen
- inv_sticky  output  1  sticky: any invalid operation seen

Behaviour:
- Reset (asynchronous, active-high): all registers and outputs go to 0, including out_valid and both sticky flags. Reset asserted mid-operation discards in-flight data.
- Classification, per operand x:
  - exp = x[30:23], frac = x[22:0]
  - NaN: exp == 8'hFF and frac != 0
  - SNaN: NaN and frac[22] == 0
  - Inf: exp == 8'hFF and frac == 0
  - Zero: exp == 0 and frac == 0
  - Denormals are not special here.
- Stage 1 (registered when stall=0): classes of A and B, signs, raw operands, op, and v1 <= in_valid.
- Stage 2 (registered when stall=0): out_valid <= v1; all outputs are computed from the stage-1 registers.
- Latency is exactly 2 unstalled cycles, in to out. Throughput is 1 per cycle.
- Pipeline registers load regardless of valid; outputs are don't-care when out_valid=0, except the sticky flags.
- Invalid (registered as invalid):
  - any SNaN input, or
  - add: both Inf with opposite signs
  - sub: both Inf with equal signs
  - mul: (Zero and Inf) in either order
  - div: both Zero, or both Inf
- nan_res = opa_nan | opb_nan | invalid.
- nan_val priority:
  1. A is NaN: opa with bit22 forced to 1
  2. else B is NaN: opb with bit22 forced to 1
  3. else invalid: QNAN_CANON
  4. else 0
- stall=1: every pipeline register holds, including out_valid; in_valid is ignored that cycle; sticky flags do not update from the pipeline.
- Sticky flags:
  - On a stage-2 load with v1=1: snan_sticky |= (snanA | snanB); inv_sticky |= the invalid being loaded.
  - flag_clr=1 clears both flags; if a set event occurs in the same cycle, the set wins (flag ends at 1).
  - flag_clr is honoured during stall.
- signa_o/signb_o are the operand sign bits, delayed 2 cycles.

Test Plan:
- Add opa=3F800000, opb=40000000, in_valid pulse at cycle 0 -> out_valid=1 at cycle 2 only; nan_res=0; nan_val=0; invalid=0; flags 0.
- Add opa=7F800000, opb=FF800000 (+Inf + -Inf) -> invalid=1, nan_res=1, nan_val=7FC00000, inv_sticky=1; same operands with op=sub -> invalid=0, nan_res=0.
- Mul opa=7F800001 (SNaN), opb=FFC00000 (QNaN) -> opa_nan=1, opb_nan=1, signb_o=1, nan_val=7FC00001, invalid=1, snan_sticky=1.
- Back-to-back valids (3 ops) with stall=1 at cycle 2 for 2 cycles -> outputs and out_valid frozen; 3 results delivered in order, none lost or duplicated.
- Div 0/0 result loading in the same cycle as flag_clr=1 -> inv_sticky=1 afterwards; flag_clr alone on the next cycle -> 0.
- rst asserted asynchronously mid-pipeline with 2 valids in flight -> out_valid and sticky flags 0 immediately; no stale result after release.

Source files
------------

// File: rtl/fp_nan_prep.sv
// fp_nan_prep: operand pre-check stage for the single-precision FPU.
// Two-stage pipeline. Stage 1 registers the operand classes. Stage 2 registers
// the NaN flags, the invalid-operation result and the NaN value. The sticky
// exception flags are updated alongside stage 2.
module fp_nan_prep #(
    parameter logic [31:0] QNAN_CANON = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic [1:0]  op,
    input  logic        stall,
    input  logic        flag_clr,
    output logic        out_valid,
    output logic        opa_nan,
    output logic        opb_nan,
    output logic        signa_o,
    output logic        signb_o,
    output logic        nan_res,
    output logic [31:0] nan_val,
    output logic        invalid,
    output logic        snan_sticky,
    output logic        inv_sticky
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    // Stage-1 state
    logic        v1_q;
    logic [31:0] a_q, b_q;
    op_e         op_q;
    logic        a_nan_q, a_snan_q, a_inf_q, a_zero_q;
    logic        b_nan_q, b_snan_q, b_inf_q, b_zero_q;

    // Stage-1 next-state (classification of the incoming operands)
    logic        a_nan_d, a_snan_d, a_inf_d, a_zero_d;
    logic        b_nan_d, b_snan_d, b_inf_d, b_zero_d;

    // Stage-2 state
    logic        out_valid_q, opa_nan_q, opb_nan_q, signa_q, signb_q;
    logic        nan_res_q, invalid_q;
    logic [31:0] nan_val_q;
    logic        snan_sticky_q, inv_sticky_q;

    // Stage-2 next-state
    logic        inv_op_d, invalid_d, nan_res_d, snan_any_d;
    logic [31:0] nan_val_d;
    logic        snan_sticky_d, inv_sticky_d;

    // Classify both incoming operands; denormals are ordinary finite values here
    always_comb begin
        a_nan_d  = (opa[30:23] == 8'hFF) && (opa[22:0] != '0);
        a_snan_d = a_nan_d && !opa[22];
        a_inf_d  = (opa[30:23] == 8'hFF) && (opa[22:0] == '0);
        a_zero_d = (opa[30:0] == '0);
        b_nan_d  = (opb[30:23] == 8'hFF) && (opb[22:0] != '0);
        b_snan_d = b_nan_d && !opb[22];
        b_inf_d  = (opb[30:23] == 8'hFF) && (opb[22:0] == '0);
        b_zero_d = (opb[30:0] == '0);
    end

    // Stage 1: capture operands and their classes unless stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            a_nan_q  <= 1'b0;
            a_snan_q <= 1'b0;
            a_inf_q  <= 1'b0;
            a_zero_q <= 1'b0;
            b_nan_q  <= 1'b0;
            b_snan_q <= 1'b0;
            b_inf_q  <= 1'b0;
            b_zero_q <= 1'b0;
        end else if (!stall) begin
            v1_q     <= in_valid;
            a_q      <= opa;
            b_q      <= opb;
            op_q     <= op_e'(op);
            a_nan_q  <= a_nan_d;
            a_snan_q <= a_snan_d;
            a_inf_q  <= a_inf_d;
            a_zero_q <= a_zero_d;
            b_nan_q  <= b_nan_d;
            b_snan_q <= b_snan_d;
            b_inf_q  <= b_inf_d;
            b_zero_q <= b_zero_d;
        end
    end

    // Invalid detection, NaN selection and sticky next-state from stage-1 registers
    always_comb begin
        snan_any_d = a_snan_q | b_snan_q;
        inv_op_d   = 1'b0;
        unique case (op_q)
            OP_ADD: inv_op_d = a_inf_q && b_inf_q && (a_q[31] != b_q[31]);
            OP_SUB: inv_op_d = a_inf_q && b_inf_q && (a_q[31] == b_q[31]);
            OP_MUL: inv_op_d = (a_zero_q && b_inf_q) || (a_inf_q && b_zero_q);
            OP_DIV: inv_op_d = (a_zero_q && b_zero_q) || (a_inf_q && b_inf_q);
            default: inv_op_d = 1'b0;
        endcase
        invalid_d = snan_any_d | inv_op_d;
        nan_res_d = a_nan_q | b_nan_q | invalid_d;

        if (a_nan_q)        nan_val_d = a_q | 32'h0040_0000;
        else if (b_nan_q)   nan_val_d = b_q | 32'h0040_0000;
        else if (invalid_d) nan_val_d = QNAN_CANON;
        else                nan_val_d = '0;

        // Clear first, then set: a set in the same cycle as flag_clr wins
        snan_sticky_d = snan_sticky_q & ~flag_clr;
        inv_sticky_d  = inv_sticky_q & ~flag_clr;
        if (!stall && v1_q) begin
            snan_sticky_d = snan_sticky_d | snan_any_d;
            inv_sticky_d  = inv_sticky_d | invalid_d;
        end
    end

    // Stage 2: register results unless stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            opa_nan_q   <= 1'b0;
            opb_nan_q   <= 1'b0;
            signa_q     <= 1'b0;
            signb_q     <= 1'b0;
            nan_res_q   <= 1'b0;
            invalid_q   <= 1'b0;
            nan_val_q   <= '0;
        end else if (!stall) begin
            out_valid_q <= v1_q;
            opa_nan_q   <= a_nan_q;
            opb_nan_q   <= b_nan_q;
            signa_q     <= a_q[31];
            signb_q     <= b_q[31];
            nan_res_q   <= nan_res_d;
            invalid_q   <= invalid_d;
            nan_val_q   <= nan_val_d;
        end
    end

    // Sticky exception flags; flag_clr is honoured even while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snan_sticky_q <= 1'b0;
            inv_sticky_q  <= 1'b0;
        end else begin
            snan_sticky_q <= snan_sticky_d;
            inv_sticky_q  <= inv_sticky_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign opa_nan     = opa_nan_q;
    assign opb_nan     = opb_nan_q;
    assign signa_o     = signa_q;
    assign signb_o     = signb_q;
    assign nan_res     = nan_res_q;
    assign nan_val     = nan_val_q;
    assign invalid     = invalid_q;
    assign snan_sticky = snan_sticky_q;
    assign inv_sticky  = inv_sticky_q;

endmodule
